// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared types and constants for the nibble-serial adder.
// Contents: FSM state enum, slice width, index width helper.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIBBLE_W = 4;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_w(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// nibble_csa_slice: 4-bit carry-select adder slice.
// Ports: a, b    - nibble operands
//        cin     - carry-in selecting between the two precomputed chains
//        sum     - nibble sum
//        cout    - nibble carry-out
module nibble_csa_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0]   c0, c1;
    logic [NIBBLE_W-1:0] s0, s1;

    // Both ripple chains run in parallel; cin only drives the final mux.
    always_comb begin
        c0 = '0;
        c1 = '0;
        s0 = '0;
        s1 = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = cin ? s1 : s0;
    assign cout = cin ? c1[NIBBLE_W] : c0[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle add/subtract, one 4-bit slice per cycle, LS nibble first.
// Ports: clk, reset_n            - clock, synchronous active-low reset
//        in_valid/in_ready       - operand handshake (a, b, cin, op_sub)
//        out_valid/out_ready     - result handshake (sum, cout, overflow)
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;
    logic [NIBBLE_W-1:0] sl_sum;
    logic               sl_cout;
    logic               last;

    assign last = (idx_q == LAST);

    nibble_csa_slice u_slice (
        .a   (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .b   (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .cin (carry_q),
        .sum (sl_sum),
        .cout(sl_cout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = op_sub ? ~b : b;
            carry_d = op_sub | cin;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = sl_sum;
            carry_d = sl_cout;
            idx_d   = last ? '0 : idx_q + 1'b1;
            if (last) begin
                cout_d = sl_cout;
                ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sl_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign in_ready  = reset_n & (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
